branch_unit_bht: RTL and testbench
==================================

Name: branch_unit_bht

Overview:
Next-generation branch resolution unit for the execute stage, parametrised in data width and predictor depth. It evaluates the branch/jump condition and registers the result. It keeps a direct-mapped table of 2-bit saturating counters (BHT) that fetch reads for prediction and execute trains on resolution. It flags mispredictions and keeps saturating performance counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >=2
CNT_W, 16, width of performance counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_pred_pc  in  XLEN  fetch PC for prediction lookup
o_pred_taken  out  1  combinational prediction = MSB of counter at pred index
i_valid  in  1  execute-stage instruction valid
i_stall  in  1  hold execute outputs; no state update
i_flush  in  1  squash current execute instruction
i_pc  in  XLEN  PC of execute-stage instruction
i_dat_a  in  XLEN  rs1 operand
i_dat_b  in  XLEN  rs2 operand
i_funct3  in  3  instruction funct3
i_opcode  in  5  instruction opcode[6:2]
i_pred_taken  in  1  prediction fetch made for this instruction
o_valid  out  1  registered result valid
o_br_en  out  1  registered: branch/jump taken
o_mispredict  out  1  registered: o_br_en != carried prediction
o_br_count  out  CNT_W  resolved conditional branches
o_miss_count  out  CNT_W  mispredictions (all control and non-control)

Behaviour:
- Index: IDX_W = log2(BHT_ENTRIES); index = pc[IDX_W+1:2] for both pred and execute PCs.
- Opcode decode: jump = 11011 or 11001; branch = 11000; anything else is a non-control instruction.
- Condition: funct3[2:1] 00 equal, 10 signed less-than, 11 unsigned less-than, 01 constant 0; funct3[0] inverts the result. Comparisons are full XLEN.
- taken = jump OR (branch AND condition). Non-control instructions are never taken.
- mispredict = taken XOR i_pred_taken, for every valid instruction.
- Accept = i_valid & ~i_stall & ~i_flush.
- Latency: inputs at cycle N produce o_valid/o_br_en/o_mispredict at N+1.
- Priority: i_rst > i_flush > i_stall.
- Flush: o_valid <= 0 next cycle. No BHT or counter update.
- Stall with no flush: all output registers, BHT and counters hold.
- Accept cycle: o_valid <= 1, o_br_en <= taken, o_mispredict <= mispredict.
- Idle cycle (no stall, no flush, i_valid=0): o_valid <= 0. o_br_en and o_mispredict <= 0.
- BHT training: only on accept of a conditional branch (opcode 11000). Jumps and non-control instructions do not train.
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- BHT write occurs at the N/N+1 clock edge. o_pred_taken is a combinational read of the array, so a same-cycle read of the index being written returns the old value; the new value is visible from N+1.
- o_br_count: +1 on each accepted conditional branch.
- o_miss_count: +1 on each accepted instruction with mispredict=1.
- Both counters saturate at all-ones and never wrap.
- Reset, synchronous: o_valid, o_br_en, o_mispredict = 0. o_br_count, o_miss_count = 0. Every BHT entry = 01 (weakly not-taken). Reset mid-operation discards the in-flight result and any pending update that cycle.
- Reset does not gate o_pred_taken; it reads the reset contents (0) on the next cycle.

Test Plan:
- Reset, then BEQ a=b=0x5, i_pred_taken=0, pc=0x100 -> N+1: o_valid=1, o_br_en=1, o_mispredict=1, o_br_count=1, o_miss_count=1; entry 0 (0x100[7:2]=0) becomes 10, so o_pred_taken=1 for i_pred_pc=0x100.
- BLT a=0xFFFFFFFF, b=1 gives taken; BLTU with the same operands gives not taken; funct3=010 gives not taken; BGEU with a=b gives taken -> o_br_en 1, 0, 0, 1 respectively.
- Four consecutive taken branches at the same PC -> counter saturates at 11. Then five not-taken -> counter reaches 00 and holds; o_pred_taken sequence matches.
- JAL with i_pred_taken=0 -> o_br_en=1, o_mispredict=1, BHT unchanged, o_br_count unchanged. ADD (opcode 01100) with i_pred_taken=1 -> o_br_en=0, o_mispredict=1.
- Branch with i_stall=1 for 3 cycles, then released -> outputs, BHT and counters frozen during the stall; a single update after release. Same branch with i_flush=1 and i_stall=1 -> o_valid=0, no update.
- CNT_W=4: 20 mispredicting branches -> o_miss_count holds at 15. Then assert i_rst mid-stream -> next cycle all outputs 0 and all entries read 01.

Source files
------------

// File: rtl/branch_unit_bht.sv
// Execute-stage branch resolution with a 2-bit-counter BHT and saturating perf counters; results one cycle after accept.
// i_stall holds every register, i_flush squashes the instruction; o_pred_taken is a combinational table read.
module branch_unit_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [XLEN-1:0]  i_pred_pc,
  output logic             o_pred_taken,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_dat_a,
  input  logic [XLEN-1:0]  i_dat_b,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_opcode,
  input  logic             i_pred_taken,
  output logic             o_valid,
  output logic             o_br_en,
  output logic             o_mispredict,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_miss_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] exe_idx;
  logic             is_jump;
  logic             is_branch;
  logic             cmp_raw;
  logic             cond;
  logic             taken;
  logic             mispredict;
  logic             accept;
  logic             unused_bits;

  assign pred_idx     = i_pred_pc[IDX_W+1:2];
  assign exe_idx      = i_pc[IDX_W+1:2];
  assign o_pred_taken = bht[pred_idx][1];

  // Only the index slice of each PC participates in lookup.
  assign unused_bits = ^{i_pred_pc[XLEN-1:IDX_W+2], i_pred_pc[1:0],
                         i_pc[XLEN-1:IDX_W+2], i_pc[1:0]};

  always_comb begin
    is_jump   = (i_opcode == 5'b11011) || (i_opcode == 5'b11001);
    is_branch = (i_opcode == 5'b11000);
    cmp_raw   = 1'b0;
    case (i_funct3[2:1])
      2'b00:   cmp_raw = (i_dat_a == i_dat_b);
      2'b01:   cmp_raw = 1'b0;
      2'b10:   cmp_raw = ($signed(i_dat_a) < $signed(i_dat_b));
      default: cmp_raw = (i_dat_a < i_dat_b);
    endcase
    cond       = cmp_raw ^ i_funct3[0];
    taken      = is_jump | (is_branch & cond);
    mispredict = taken ^ i_pred_taken;
    accept     = i_valid & ~i_stall & ~i_flush;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_br_en      <= 1'b0;
      o_mispredict <= 1'b0;
      o_br_count   <= '0;
      o_miss_count <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (i_flush) begin
      o_valid      <= 1'b0;
      o_br_en      <= 1'b0;
      o_mispredict <= 1'b0;
    end else if (!i_stall) begin
      o_valid      <= accept;
      o_br_en      <= accept & taken;
      o_mispredict <= accept & mispredict;
      if (accept && is_branch) begin
        if (!(&o_br_count)) o_br_count <= o_br_count + 1'b1;
        // Saturating 2-bit counter: train toward the resolved direction.
        if (taken && bht[exe_idx] != 2'b11)
          bht[exe_idx] <= bht[exe_idx] + 2'b01;
        else if (!taken && bht[exe_idx] != 2'b00)
          bht[exe_idx] <= bht[exe_idx] - 2'b01;
      end
      if (accept && mispredict && !(&o_miss_count))
        o_miss_count <= o_miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed plus randomized bench for branch_unit_bht against a table-driven reference model.
module tb_branch_unit_bht;

  localparam int ENTRIES = 64;
  localparam int CMAX    = 15;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_pred_pc = '0;
  logic        o_pred_taken;
  logic        i_valid = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_dat_a = '0;
  logic [31:0] i_dat_b = '0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_opcode = '0;
  logic        i_pred_taken = 1'b0;
  logic        o_valid;
  logic        o_br_en;
  logic        o_mispredict;
  logic [3:0]  o_br_count;
  logic [3:0]  o_miss_count;

  branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(ENTRIES), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_pred_pc(i_pred_pc), .o_pred_taken(o_pred_taken),
    .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush), .i_pc(i_pc),
    .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_funct3(i_funct3), .i_opcode(i_opcode),
    .i_pred_taken(i_pred_taken), .o_valid(o_valid), .o_br_en(o_br_en),
    .o_mispredict(o_mispredict), .o_br_count(o_br_count), .o_miss_count(o_miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int bht_m [ENTRIES];
  int br_m, miss_m;
  bit ev, eb, em, known, pred_chk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // Branch outcome from the funct3 mnemonic table.
  function automatic bit cond_m(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = a[31] ? ua - 64'sd4294967296 : ua;
    longint sb = b[31] ? ub - 64'sd4294967296 : ub;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1'b0;
      3'd3: return 1'b1;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  task automatic model_edge();
    bit jump, branch, tk, mis;
    int k;
    if (i_rst) begin
      ev = 0; eb = 0; em = 0; known = 1; br_m = 0; miss_m = 0;
      for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
    end else if (i_flush) begin
      ev = 0; known = 0;
    end else if (i_stall) begin
      // everything holds
    end else if (i_valid) begin
      jump   = (i_opcode == 5'b11011) || (i_opcode == 5'b11001);
      branch = (i_opcode == 5'b11000);
      tk  = jump || (branch && cond_m(i_funct3, i_dat_a, i_dat_b));
      mis = tk ^ i_pred_taken;
      ev = 1; eb = tk; em = mis; known = 1;
      if (branch) begin
        if (br_m < CMAX) br_m++;
        k = idx_of(i_pc);
        if (tk && bht_m[k] < 3) bht_m[k]++;
        else if (!tk && bht_m[k] > 0) bht_m[k]--;
      end
      if (mis && miss_m < CMAX) miss_m++;
    end else begin
      ev = 0; eb = 0; em = 0; known = 1;
    end
  endtask

  task automatic cyc(string tag);
    @(negedge clk);
    if (pred_chk) check({tag, ".pred"}, 32'(o_pred_taken), 32'(bht_m[idx_of(i_pred_pc)] >= 2));
    @(posedge clk);
    model_edge();
    pred_chk = 1;
    #1;
    check({tag, ".valid"}, 32'(o_valid), 32'(ev));
    if (known) begin
      check({tag, ".br_en"}, 32'(o_br_en), 32'(eb));
      check({tag, ".mispred"}, 32'(o_mispredict), 32'(em));
    end
    check({tag, ".br_cnt"}, 32'(o_br_count), 32'(br_m));
    check({tag, ".miss_cnt"}, 32'(o_miss_count), 32'(miss_m));
  endtask

  task automatic set_instr(logic [4:0] op, logic [2:0] f3, logic [31:0] pc,
                           logic [31:0] a, logic [31:0] b, logic pt);
    i_valid = 1; i_opcode = op; i_funct3 = f3; i_pc = pc;
    i_dat_a = a; i_dat_b = b; i_pred_taken = pt; i_pred_pc = pc;
  endtask

  logic [4:0] ops [5];

  initial begin
    pred_chk = 0;
    ops[0] = 5'b11000; ops[1] = 5'b11011; ops[2] = 5'b11001; ops[3] = 5'b01100; ops[4] = 5'b11000;
    for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
    br_m = 0; miss_m = 0; ev = 0; eb = 0; em = 0; known = 1;

    cyc("reset0");
    cyc("reset1");
    i_rst = 0;
    cyc("idle");

    // BEQ equal operands, predicted not taken
    set_instr(5'b11000, 3'b000, 32'h100, 32'h5, 32'h5, 1'b0);
    cyc("beq");
    i_valid = 0; i_pred_pc = 32'h100;
    cyc("beq_pred");

    set_instr(5'b11000, 3'b100, 32'h300, 32'hFFFF_FFFF, 32'h1, 1'b0); cyc("blt");
    set_instr(5'b11000, 3'b110, 32'h304, 32'hFFFF_FFFF, 32'h1, 1'b0); cyc("bltu");
    set_instr(5'b11000, 3'b010, 32'h308, 32'h7, 32'h7, 1'b0);         cyc("f3_010");
    set_instr(5'b11000, 3'b111, 32'h30C, 32'h9, 32'h9, 1'b0);         cyc("bgeu");

    for (int i = 0; i < 4; i++) begin
      set_instr(5'b11000, 3'b001, 32'h200, 32'h1, 32'h2, 1'b1); cyc("sat_up");
    end
    for (int i = 0; i < 5; i++) begin
      set_instr(5'b11000, 3'b001, 32'h200, 32'h3, 32'h3, 1'b0); cyc("sat_dn");
    end
    i_valid = 0; cyc("sat_pred");

    set_instr(5'b11011, 3'b000, 32'h400, 32'h0, 32'h1, 1'b0); cyc("jal");
    set_instr(5'b11001, 3'b000, 32'h404, 32'h0, 32'h1, 1'b1); cyc("jalr");
    set_instr(5'b01100, 3'b000, 32'h408, 32'h4, 32'h4, 1'b1); cyc("add");
    i_valid = 0; i_pred_pc = 32'h400; cyc("jal_pred");

    set_instr(5'b11000, 3'b000, 32'h500, 32'h8, 32'h8, 1'b0);
    i_stall = 1;
    for (int i = 0; i < 3; i++) cyc("stall");
    i_stall = 0; cyc("release");
    i_valid = 0; cyc("release_pred");
    set_instr(5'b11000, 3'b000, 32'h500, 32'h8, 32'h8, 1'b0);
    i_flush = 1; i_stall = 1; cyc("flush_stall");
    i_flush = 0; i_stall = 0; i_valid = 0; cyc("after_flush");

    // Mispredicting branches drive both counters into saturation.
    for (int i = 0; i < 20; i++) begin
      set_instr(5'b11000, 3'b000, 32'h600 + 32'(i * 4), 32'h1, 32'h1, 1'b0); cyc("miss_sat");
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      i_rst   = ($urandom_range(0, 99) == 0);
      i_flush = ($urandom_range(0, 7) == 0);
      i_stall = ($urandom_range(0, 4) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_opcode = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 4)];
      i_funct3 = 3'($urandom);
      i_pc      = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2) | ($urandom & 32'h3);
      i_pred_pc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2);
      a = $urandom;
      i_dat_a = a;
      case ($urandom_range(0, 2))
        0: i_dat_b = a;
        1: i_dat_b = a ^ 32'h8000_0000;
        default: i_dat_b = $urandom;
      endcase
      i_pred_taken = 1'($urandom);
      cyc("rand");
    end
    i_rst = 0; i_flush = 0; i_stall = 0;

    // Reset with a live mispredicting branch: result and training discarded.
    set_instr(5'b11000, 3'b000, 32'h700, 32'h1, 32'h1, 1'b0); cyc("pre_rst");
    i_rst = 1; cyc("mid_rst");
    i_rst = 0; i_valid = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      i_pred_pc = 32'(i << 2);
      cyc("scan");
    end
    // One taken branch from weakly-not-taken must flip the prediction.
    set_instr(5'b11000, 3'b000, 32'h14, 32'h2, 32'h2, 1'b0); cyc("retrain");
    i_valid = 0; cyc("retrain_pred");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
